// File: rtl/ring_seq_pkg.sv
// Shared types and helpers for the ring-code sequence monitor.
// Helpers operate on RING_MAX_W-wide vectors and take the live ring width as an argument.
package ring_seq_pkg;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_TRACK    = 2'd1,
      ST_LOCKED   = 2'd2
   } ring_state_t;

   localparam int unsigned RING_MAX_W = 32;
   localparam logic [RING_MAX_W-1:0] RING_START = 32'd1;

   // Successor of a ring code: bit i takes bit (i+1) mod w, so the set bit moves down by one.
   function automatic logic [RING_MAX_W-1:0] ring_succ(input logic [RING_MAX_W-1:0] r,
                                                       input int unsigned w);
      logic [RING_MAX_W-1:0] e;
      e = {RING_MAX_W{1'b0}};
      for (int unsigned i = 0; i < RING_MAX_W; i++) begin
         if (i < w) begin
            e[i] = r[(i + 32'd1) % w];
         end else begin
            e[i] = 1'b0;
         end
      end
      return e;
   endfunction

   function automatic logic ring_is_onehot(input logic [RING_MAX_W-1:0] v,
                                           input int unsigned w);
      int unsigned ones;
      ones = 32'd0;
      for (int unsigned i = 0; i < RING_MAX_W; i++) begin
         if ((i < w) && v[i]) begin
            ones = ones + 32'd1;
         end else begin
            ones = ones;
         end
      end
      return (ones == 32'd1);
   endfunction

endpackage

// File: rtl/ring_onehot_dec.sv
// Combinational ring-code to binary index encoder with a one-hot validity flag.
// Any code that is not exactly one-hot decodes to index 0.
module ring_onehot_dec
   import ring_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]         din,
   output logic [$clog2(WIDTH)-1:0] idx,
   output logic                     onehot
);

   localparam int IDX_W = $clog2(WIDTH);

   // Encode the set bit position, forcing 0 for illegal codes.
   always_comb begin
      idx    = {IDX_W{1'b0}};
      onehot = ring_is_onehot(RING_MAX_W'(din), WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot && din[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/ring_seq_monitor.sv
// Receive-side health monitor for a one-hot ring counter: decode, lock tracking, error count.
// Optional build macro RING_SEQ_MONITOR_REV_CNT_EN adds a 16-bit revolution counter output rev_cnt.
module ring_seq_monitor
   import ring_seq_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int LOCK_LEN  = 3,
   parameter int ERR_CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         din,
   input  logic                     din_valid,
   output logic [$clog2(WIDTH)-1:0] idx,
   output logic                     idx_valid,
   output logic                     onehot_ok,
   output logic                     seq_err,
   output logic                     locked,
   output logic [ERR_CNT_W-1:0]     err_cnt
`ifdef RING_SEQ_MONITOR_REV_CNT_EN
   ,
   output logic [15:0]              rev_cnt
`endif
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(LOCK_LEN + 1);
   localparam logic [CNT_W-1:0]     LOCK_LEN_C = CNT_W'(LOCK_LEN);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX_C  = {ERR_CNT_W{1'b1}};

   logic [IDX_W-1:0]      dec_idx_s;
   logic                  dec_onehot_s;
   logic [RING_MAX_W-1:0] succ_s;
   logic [WIDTH-1:0]      exp_s;
   logic                  is_succ_s;
   logic [CNT_W-1:0]      cnt_inc_s;
   logic [ERR_CNT_W-1:0]  err_nxt_s;

   ring_state_t           state_r;
   logic [WIDTH-1:0]      ref_r;
   logic [CNT_W-1:0]      cnt_r;

   ring_onehot_dec #(.WIDTH(WIDTH)) u_dec (
      .din    (din),
      .idx    (dec_idx_s),
      .onehot (dec_onehot_s)
   );

   assign succ_s    = ring_succ(RING_MAX_W'(ref_r), WIDTH);
   assign exp_s     = succ_s[WIDTH-1:0];
   assign is_succ_s = (din == exp_s);
   assign cnt_inc_s = cnt_r + CNT_W'(1);
   // Saturate rather than wrap so a long-running fault never reads as healthy.
   assign err_nxt_s = (err_cnt == ERR_MAX_C) ? err_cnt : (err_cnt + ERR_CNT_W'(1));

   // Lock FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_UNLOCKED;
         ref_r     <= {WIDTH{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         idx       <= {IDX_W{1'b0}};
         idx_valid <= 1'b0;
         onehot_ok <= 1'b0;
         seq_err   <= 1'b0;
         locked    <= 1'b0;
         err_cnt   <= {ERR_CNT_W{1'b0}};
`ifdef RING_SEQ_MONITOR_REV_CNT_EN
         rev_cnt   <= 16'd0;
`endif
      end else begin
         seq_err   <= 1'b0;
         idx_valid <= din_valid;
         if (din_valid) begin
            idx       <= dec_idx_s;
            onehot_ok <= dec_onehot_s;
            case (state_r)
               ST_UNLOCKED: begin
                  if (dec_onehot_s) begin
                     state_r <= ST_TRACK;
                     ref_r   <= din;
                     cnt_r   <= {CNT_W{1'b0}};
                  end else begin
                     state_r <= ST_UNLOCKED;
                  end
               end
               ST_TRACK: begin
                  // A successor of a one-hot reference is itself one-hot.
                  if (is_succ_s) begin
                     ref_r <= din;
                     if (cnt_inc_s == LOCK_LEN_C) begin
                        state_r <= ST_LOCKED;
                        locked  <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                     end else begin
                        cnt_r   <= cnt_inc_s;
                     end
                  end else if (dec_onehot_s) begin
                     ref_r <= din;
                     cnt_r <= {CNT_W{1'b0}};
                  end else begin
                     state_r <= ST_UNLOCKED;
                  end
               end
               ST_LOCKED: begin
                  if (is_succ_s) begin
                     ref_r <= din;
`ifdef RING_SEQ_MONITOR_REV_CNT_EN
                     if (din == RING_START[WIDTH-1:0]) begin
                        rev_cnt <= rev_cnt + 16'd1;
                     end else begin
                        rev_cnt <= rev_cnt;
                     end
`endif
                  end else if (dec_onehot_s) begin
                     seq_err <= 1'b1;
                     err_cnt <= err_nxt_s;
                     state_r <= ST_TRACK;
                     locked  <= 1'b0;
                     ref_r   <= din;
                     cnt_r   <= {CNT_W{1'b0}};
                  end else begin
                     seq_err <= 1'b1;
                     err_cnt <= err_nxt_s;
                     state_r <= ST_UNLOCKED;
                     locked  <= 1'b0;
                  end
               end
               default: begin
                  state_r <= ST_UNLOCKED;
                  locked  <= 1'b0;
               end
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Directed self-checking bench for ring_seq_monitor (default and 2-bit error counter instances).
module tb_ring_seq_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       din_valid;
   logic [3:0] din;

   logic [1:0] idx;
   logic       idx_valid, onehot_ok, seq_err, locked;
   logic [7:0] err_cnt;

   logic [1:0] s_idx;
   logic       s_idx_valid, s_onehot_ok, s_seq_err, s_locked;
   logic [1:0] s_err_cnt;

`ifdef RING_SEQ_MONITOR_REV_CNT_EN
   logic [15:0] rev_cnt, s_rev_cnt;
`endif

   int checks = 0;
   int errors = 0;

   ring_seq_monitor #(.WIDTH(4), .LOCK_LEN(3), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .idx(idx), .idx_valid(idx_valid), .onehot_ok(onehot_ok),
      .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
`ifdef RING_SEQ_MONITOR_REV_CNT_EN
      , .rev_cnt(rev_cnt)
`endif
   );

   ring_seq_monitor #(.WIDTH(4), .LOCK_LEN(3), .ERR_CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .idx(s_idx), .idx_valid(s_idx_valid), .onehot_ok(s_onehot_ok),
      .seq_err(s_seq_err), .locked(s_locked), .err_cnt(s_err_cnt)
`ifdef RING_SEQ_MONITOR_REV_CNT_EN
      , .rev_cnt(s_rev_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [3:0] d);
      din_valid = v;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] seq_v [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
   int         seq_i [5] = '{0, 3, 2, 1, 0};
   int         seq_l [5] = '{0, 0, 0, 1, 1};
   logic [3:0] cur;
   int         pulses;

   initial begin
      rst = 1'b1; din_valid = 1'b0; din = 4'b0000;
      step(1'b0, 4'b0000);
      step(1'b1, 4'b0001);
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_idx_valid", 32'(idx_valid), 32'd0);
      chk("rst_onehot_ok", 32'(onehot_ok), 32'd0);
      chk("rst_seq_err", 32'(seq_err), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_s_err_cnt", 32'(s_err_cnt), 32'd0);
      rst = 1'b0;

      // Lock acquisition
      for (int i = 0; i < 5; i++) begin
         step(1'b1, seq_v[i]);
         chk($sformatf("acq_idx%0d", i), 32'(idx), 32'(seq_i[i]));
         chk($sformatf("acq_vld%0d", i), 32'(idx_valid), 32'd1);
         chk($sformatf("acq_ok%0d", i), 32'(onehot_ok), 32'd1);
         chk($sformatf("acq_lock%0d", i), 32'(locked), 32'(seq_l[i]));
         chk($sformatf("acq_err%0d", i), 32'(seq_err), 32'd0);
      end
      chk("acq_err_cnt", 32'(err_cnt), 32'd0);
`ifdef RING_SEQ_MONITOR_REV_CNT_EN
      chk("acq_rev_cnt", 32'(rev_cnt), 32'd1);
`endif

      // Successor error: repeat 0010 while locked
      step(1'b1, 4'b1000);
      step(1'b1, 4'b0100);
      step(1'b1, 4'b0010);
      chk("succ_pre_lock", 32'(locked), 32'd1);
      step(1'b1, 4'b0010);
      chk("succ_seq_err", 32'(seq_err), 32'd1);
      chk("succ_err_cnt", 32'(err_cnt), 32'd1);
      chk("succ_locked", 32'(locked), 32'd0);
      step(1'b0, 4'b0000);
      chk("succ_pulse_end", 32'(seq_err), 32'd0);
      step(1'b1, 4'b0001);
      chk("relock0", 32'(locked), 32'd0);
      step(1'b1, 4'b1000);
      chk("relock1", 32'(locked), 32'd0);
      step(1'b1, 4'b0100);
      chk("relock2", 32'(locked), 32'd1);
      chk("relock2_err", 32'(seq_err), 32'd0);

      // Non-one-hot while locked, then zero code while unlocked
      step(1'b1, 4'b0110);
      chk("noh_ok", 32'(onehot_ok), 32'd0);
      chk("noh_idx", 32'(idx), 32'd0);
      chk("noh_seq_err", 32'(seq_err), 32'd1);
      chk("noh_err_cnt", 32'(err_cnt), 32'd2);
      chk("noh_locked", 32'(locked), 32'd0);
      step(1'b1, 4'b0000);
      chk("zero_ok", 32'(onehot_ok), 32'd0);
      chk("zero_seq_err", 32'(seq_err), 32'd0);
      chk("zero_err_cnt", 32'(err_cnt), 32'd2);

      // Valid gaps of two cycles between samples
      for (int i = 0; i < 4; i++) begin
         step(1'b1, seq_v[i]);
         chk($sformatf("gap_idx%0d", i), 32'(idx), 32'(seq_i[i]));
         chk($sformatf("gap_lock%0d", i), 32'(locked), 32'(seq_l[i]));
         for (int g = 0; g < 2; g++) begin
            step(1'b0, 4'b1111);
            chk($sformatf("gap_vld%0d_%0d", i, g), 32'(idx_valid), 32'd0);
            chk($sformatf("gap_hold%0d_%0d", i, g), 32'(idx), 32'(seq_i[i]));
            chk($sformatf("gap_okh%0d_%0d", i, g), 32'(onehot_ok), 32'd1);
            chk($sformatf("gap_lockh%0d_%0d", i, g), 32'(locked), 32'(seq_l[i]));
            chk($sformatf("gap_err%0d_%0d", i, g), 32'(seq_err), 32'd0);
         end
      end
      chk("gap_err_cnt", 32'(err_cnt), 32'd2);

      // Saturation on the 2-bit counter instance
      rst = 1'b1;
      step(1'b0, 4'b0000);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, seq_v[i]);
      chk("sat_locked", 32'(s_locked), 32'd1);
      cur = 4'b0010;
      pulses = 0;
      for (int k = 1; k <= 5; k++) begin
         step(1'b1, cur);
         pulses += int'(s_seq_err);
         chk($sformatf("sat_cnt%0d", k), 32'(s_err_cnt), (k > 3) ? 32'd3 : 32'(k));
         chk($sformatf("sat_lock%0d", k), 32'(s_locked), 32'd0);
         for (int j = 0; j < 3; j++) begin
            cur = {cur[0], cur[3:1]};
            step(1'b1, cur);
            pulses += int'(s_seq_err);
         end
         chk($sformatf("sat_relock%0d", k), 32'(s_locked), 32'd1);
      end
      chk("sat_pulses", 32'(pulses), 32'd5);

      // Reset mid-lock with a valid sample present
      chk("mid_pre_lock", 32'(locked), 32'd1);
      rst = 1'b1;
      step(1'b1, 4'b1000);
      rst = 1'b0;
      chk("mid_idx", 32'(idx), 32'd0);
      chk("mid_vld", 32'(idx_valid), 32'd0);
      chk("mid_ok", 32'(onehot_ok), 32'd0);
      chk("mid_locked", 32'(locked), 32'd0);
      chk("mid_err_cnt", 32'(err_cnt), 32'd0);
      chk("mid_s_err_cnt", 32'(s_err_cnt), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, seq_v[i]);
         chk($sformatf("mid_lock%0d", i), 32'(locked), 32'(seq_l[i]));
      end
      chk("mid_end_err", 32'(err_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ring_seq_monitor.md
Name: ring_seq_monitor

Overview:
- Receive-side checker for the team's 4-bit one-hot ring counter.
- Samples a ring-code bus and decodes it to a binary index.
- Checks that each valid sample is the correct successor of the previous one, acquires and holds lock, and flags and counts sequence errors.
- Sits downstream of any ring counter whose output crosses a block boundary; used as a health monitor.

Parameters:
- WIDTH, 4, ring width in bits (>=2).
- LOCK_LEN, 3, consecutive correct transitions required to declare lock (>=1).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- din  input  WIDTH  sampled ring code.
- din_valid  input  1  din is meaningful this cycle.
- idx  output  $clog2(WIDTH)  binary position of the set bit.
- idx_valid  output  1  idx/onehot_ok correspond to a sample taken the previous cycle.
- onehot_ok  output  1  last sample had exactly one bit set.
- seq_err  output  1  one-cycle pulse on an error while locked.
- locked  output  1  monitor is in LOCKED.
- err_cnt  output  ERR_CNT_W  saturating count of seq_err pulses.

Behaviour:
- Clock and reset: clk; rst is synchronous, active-high.
- Reset values: all outputs 0, state UNLOCKED, reference register 0, good-transition count 0. rst overrides din_valid; assertion mid-operation clears lock and err_cnt.
- Legal sequence: 0001 -> 1000 -> 0100 -> 0010 -> 0001. Expected successor of ref: exp[i] = ref[(i+1) mod WIDTH].
- Latency: all outputs registered. The sample taken at edge k is reflected in outputs after edge k.
- din_valid low: state, ref, count and err_cnt hold; idx_valid=0; seq_err=0; idx/onehot_ok hold their last values.
- Decode: idx = index of the set bit. A non-one-hot sample (0 bits or >1 bits set) gives idx=0 and onehot_ok=0.
- States (transitions on valid samples only):
  - UNLOCKED:
    - one-hot sample -> TRACK, ref=sample, cnt=0.
    - otherwise stay.
  - TRACK:
    - sample==exp -> cnt+1, ref=sample; when cnt+1==LOCK_LEN -> LOCKED and cnt=0.
    - one-hot but !=exp -> stay TRACK, ref=sample, cnt=0.
    - non-one-hot -> UNLOCKED.
    - No seq_err in TRACK.
  - LOCKED:
    - sample==exp -> stay, ref=sample.
    - one-hot but !=exp -> seq_err=1, err_cnt+1, TRACK, ref=sample, cnt=0.
    - non-one-hot -> seq_err=1, err_cnt+1, UNLOCKED.
- locked equals (state==LOCKED) after each edge.
- err_cnt saturates at all-ones and never wraps. seq_err still pulses when err_cnt is saturated.
- A repeated identical sample is an error (not a successor).

Optional Feature:
- Macro: RING_SEQ_MONITOR_REV_CNT_EN.
- Defined: adds output rev_cnt (16 bits), reset 0. It increments (wrapping) on each valid sample accepted in LOCKED that equals 0...01 (idx 0) and is a correct successor.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package ring_seq_pkg:
  - state encoding (UNLOCKED, TRACK, LOCKED);
  - ring start pattern constant (0...01);
  - rotate-successor function;
  - one-hot-check function.
- One sub-module: ring_onehot_dec. Combinational WIDTH-to-index encoder that also outputs the one-hot-valid flag. Instantiated once.

Test Plan:
- Lock acquisition: after rst, drive valid 0001,1000,0100,0010,0001 on consecutive cycles -> idx 0,3,2,1,0; idx_valid=1 each; locked rises with the output of the 4th sample (0010); seq_err never asserted; err_cnt=0.
- Successor error: while locked after 0010, drive 0010 again -> seq_err pulse for exactly 1 cycle, err_cnt=1, locked=0; then drive 0001,1000,0100 -> locked=1 again with the output of 0100.
- Non-one-hot: while locked, drive 0110 -> onehot_ok=0, idx=0, seq_err pulse, err_cnt+1, locked=0; then drive 0000 -> onehot_ok=0, no seq_err (UNLOCKED).
- Valid gaps: legal sequence with din_valid low for 2 cycles between each sample -> idx_valid low during gaps, no state change, locked after the 4th valid sample, no errors.
- Saturation: ERR_CNT_W=2, cause 5 locked errors (relocking in between) -> err_cnt 1,2,3,3,3; 5 seq_err pulses.
- Reset mid-lock: assert rst for 1 cycle with din_valid=1 and din=1000 -> next cycle all outputs 0, locked=0, err_cnt=0; relock needs a full LOCK_LEN run.
